mod_counter: RTL

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter_pkg.sv | 16 +
 rtl/mod_counter_if.sv | 40 ++++
 rtl/mod_counter_prescaler.sv | 33 +++
 rtl/mod_counter.sv | 93 +++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo up/down counter.
// Optional prescaler feature: MOD_COUNTER_PRESCALE_EN.
package mod_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_e;

   typedef enum logic {
      ST_COUNT = 1'b0,
      ST_HALT  = 1'b1
   } state_e;

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter.
// Carries the prescale field only under MOD_COUNTER_PRESCALE_EN.
interface mod_counter_if #(
   parameter int N          = 8,
   parameter int PRESCALE_W = 4
);
   logic         enable;
   logic         up_down;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] modulo;
   logic [1:0]   mode;
   logic [N-1:0] count;
   logic         tc;
   logic         done;
`ifdef MOD_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif

`ifdef MOD_COUNTER_PRESCALE_EN
   modport master (
      output enable, up_down, load, load_val, modulo, mode, prescale,
      input  count, tc, done
   );
   modport slave (
      input  enable, up_down, load, load_val, modulo, mode, prescale,
      output count, tc, done
   );
`else
   modport master (
      output enable, up_down, load, load_val, modulo, mode,
      input  count, tc, done
   );
   modport slave (
      input  enable, up_down, load, load_val, modulo, mode,
      output count, tc, done
   );
`endif

endinterface

// File: rtl/mod_counter_prescaler.sv
// Enable-gated tick divider: fires every (prescale+1)-th enable cycle.
// Present only when MOD_COUNTER_PRESCALE_EN is defined.
`ifdef MOD_COUNTER_PRESCALE_EN
module mod_counter_prescaler #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         clear,
   input  logic [W-1:0] prescale,
   output logic         tick
);
   logic [W-1:0] cnt_q, cnt_d;

   assign tick = enable && (cnt_q >= prescale);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap, saturate and one-shot modes.
// Define MOD_COUNTER_PRESCALE_EN to add the tick prescaler.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int N          = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic     clk,
   input  logic     rst,
   mod_counter_if.slave bus
);
   logic [N-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   state_e       state_q, state_d;
   logic         tick;
   logic [N-1:0] tv;
   logic [N-1:0] step;
   logic [N-1:0] nxt;
   logic         at_term;
   logic         halted;
   logic         sat_like;
   logic         oneshot;

`ifdef MOD_COUNTER_PRESCALE_EN
   mod_counter_prescaler #(.W(PRESCALE_W)) u_presc (
      .clk      (clk),
      .rst      (rst),
      .enable   (bus.enable),
      .clear    (bus.load),
      .prescale (bus.prescale),
      .tick     (tick)
   );
`else
   logic unused_pw;
   assign unused_pw = ^PRESCALE_W;
   assign tick      = bus.enable;
`endif

   assign oneshot  = (bus.mode == MODE_ONESHOT);
   assign sat_like = (bus.mode == MODE_SAT) || oneshot;
   assign halted   = (state_q == ST_HALT) && oneshot;

   always_comb begin
      tv      = bus.up_down ? bus.modulo : '0;
      at_term = bus.up_down ? (count_q >= bus.modulo)
                            : (count_q == '0);
      step    = bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
      // modulo may have dropped below count; never step above it
      if (step > bus.modulo) step = bus.modulo;
      if (!at_term)      nxt = step;
      else if (sat_like) nxt = tv;
      else               nxt = bus.up_down ? '0 : bus.modulo;
   end

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      state_d = state_q;
      if (bus.load) begin
         count_d = (bus.load_val > bus.modulo) ? bus.modulo
                                               : bus.load_val;
         state_d = ST_COUNT;
      end else if (bus.modulo == '0) begin
         count_d = '0;
         state_d = ST_COUNT;
      end else if (!halted) begin
         state_d = ST_COUNT;
         if (tick) begin
            count_d = nxt;
            tc_d    = (nxt == tv) && (count_q != tv);
            if (oneshot && nxt == tv) state_d = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         state_q <= ST_COUNT;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.done  = (state_q == ST_HALT);

endmodule
